ps2_kbd_fifo: RTL and testbench

Parametrised PS/2 keyboard receiver with a scan-code FIFO. It synchronises the PS/2 clock and data lines into the system clock domain and deframes 11-bit device-to-host frames, checking start, odd parity and stop bits. It folds the E0 (extended) and F0 (release) prefixes into per-code flags and queues the decoded codes in a show-ahead FIFO with a pop handshake. It sits between the keyboard pins and the CPU-side port/IRQ logic, and replaces the single-byte, strobe-only receiver.

---
 rtl/ps2_kbd_fifo.sv | 260 ++++++++++++++++++++++++++
 tb/tb_ps2_kbd_fifo.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_kbd_fifo.sv
// PS/2 keyboard receiver with scan-code FIFO.
// Synchronises the PS/2 pins, deframes 11-bit device-to-host frames
// (start, 8 data LSB-first, odd parity, stop), folds E0/F0 prefixes into
// per-code flags and queues {ext, rel, code} in a show-ahead FIFO.
module ps2_kbd_fifo #(
  parameter int CLK_HZ      = 25000000,
  parameter int TIMEOUT_MS  = 2,
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          ps_clock,
  input  logic                          ps_data,
  input  logic                          rd,
  output logic                          valid,
  output logic [7:0]                    data,
  output logic                          extended,
  output logic                          released,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          err,
  output logic                          overflow
);

  localparam int TIMEOUT_CYC = CLK_HZ / 1000 * TIMEOUT_MS;
  localparam int TMO_W       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RECV = 1'b1;

  // Odd parity holds when data bits plus parity bit XOR to 1.
  function automatic logic odd_parity_ok(input logic [8:0] bits);
    return ^bits;
  endfunction

  // ---------------------------------------------------------------------
  // Pin synchronisers and falling-edge detect
  // ---------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_dat_sync;
  logic                   r_clk_prev;
  logic                   w_clk_s;
  logic                   w_dat_s;
  logic                   w_fall;

  assign w_clk_s = r_clk_sync[SYNC_STAGES-1];
  assign w_dat_s = r_dat_sync[SYNC_STAGES-1];
  assign w_fall  = (w_clk_s == 1'b0) && (r_clk_prev == 1'b1);

  // Shift raw pins through the synchroniser chains; idle bus level is 1.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_clk_sync <= '1;
      r_dat_sync <= '1;
      r_clk_prev <= 1'b1;
    end else begin
      r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], ps_clock};
      r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], ps_data};
      r_clk_prev <= w_clk_s;
    end
  end

  // ---------------------------------------------------------------------
  // Frame receiver
  // ---------------------------------------------------------------------
  logic [0:0]       r_state;
  logic [3:0]       r_bitcnt;
  logic [8:0]       r_shift;     // [7:0] data bits, [8] parity once complete
  logic [TMO_W-1:0] r_tmo;
  logic             r_pend_ext;
  logic             r_pend_rel;
  logic             r_err;

  logic       w_last_edge;
  logic       w_frame_ok;
  logic [7:0] w_code;
  logic       w_is_e0;
  logic       w_is_f0;
  logic       w_push_req;
  logic [9:0] w_entry;

  assign w_last_edge = (r_state == ST_RECV) && w_fall && (r_bitcnt == 4'd10);
  assign w_frame_ok  = odd_parity_ok(r_shift) && (w_dat_s == 1'b1);
  assign w_code      = r_shift[7:0];
  assign w_is_e0     = (w_code == 8'hE0);
  assign w_is_f0     = (w_code == 8'hF0);
  assign w_push_req  = w_last_edge && w_frame_ok && !w_is_e0 && !w_is_f0;
  assign w_entry     = {r_pend_ext, r_pend_rel, w_code};

  // Deframing FSM with stall timeout, prefix tracking and error pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_bitcnt   <= 4'd0;
      r_shift    <= 9'd0;
      r_tmo      <= '0;
      r_pend_ext <= 1'b0;
      r_pend_rel <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_tmo <= '0;
          if (w_fall && (w_dat_s == 1'b0)) begin
            r_state  <= ST_RECV;
            r_bitcnt <= 4'd1;
          end else begin
            r_bitcnt <= 4'd0;
          end
        end
        ST_RECV: begin
          if (w_fall) begin
            r_tmo <= '0;
            if (r_bitcnt == 4'd10) begin
              r_state  <= ST_IDLE;
              r_bitcnt <= 4'd0;
              if (w_frame_ok) begin
                if (w_is_e0) begin
                  r_pend_ext <= 1'b1;
                end else if (w_is_f0) begin
                  r_pend_rel <= 1'b1;
                end else begin
                  r_pend_ext <= 1'b0;
                  r_pend_rel <= 1'b0;
                end
              end else begin
                r_err      <= 1'b1;
                r_pend_ext <= 1'b0;
                r_pend_rel <= 1'b0;
              end
            end else begin
              r_shift  <= {w_dat_s, r_shift[8:1]};
              r_bitcnt <= r_bitcnt + 4'd1;
            end
          end else if (r_tmo == TMO_LAST) begin
            r_state    <= ST_IDLE;
            r_bitcnt   <= 4'd0;
            r_tmo      <= '0;
            r_err      <= 1'b1;
            r_pend_ext <= 1'b0;
            r_pend_rel <= 1'b0;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_bitcnt <= 4'd0;
          r_tmo    <= '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Show-ahead FIFO
  // ---------------------------------------------------------------------
  logic [9:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_valid;
  logic [9:0]    r_head;
  logic          r_overflow;

  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic [AW-1:0] w_rd_ptr_nx;
  logic [CW-1:0] w_count_nx;
  logic [9:0]    w_head_nx;

  assign w_full      = (r_count == CNT_FULL);
  assign w_pop       = rd && r_valid;
  assign w_push      = w_push_req && (!w_full || w_pop);
  assign w_drop      = w_push_req && w_full && !w_pop;
  assign w_rd_ptr_nx = r_rd_ptr + 1'b1;

  // Next occupancy from the push/pop combination.
  always_comb begin
    w_count_nx = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nx = r_count + 1'b1;
      2'b01:   w_count_nx = r_count - 1'b1;
      default: w_count_nx = r_count;
    endcase
  end

  // Next head entry so the show-ahead outputs come straight from a register.
  always_comb begin
    w_head_nx = r_head;
    if (w_pop) begin
      if (r_count > CNT_ONE) begin
        w_head_nx = r_mem[w_rd_ptr_nx];
      end else if (w_push) begin
        w_head_nx = w_entry;
      end else begin
        w_head_nx = 10'd0;
      end
    end else if (w_push && (r_count == '0)) begin
      w_head_nx = w_entry;
    end else begin
      w_head_nx = r_head;
    end
  end

  // FIFO storage write port.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= 10'd0;
      end
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= w_entry;
    end else begin
      r_mem[r_wr_ptr] <= r_mem[r_wr_ptr];
    end
  end

  // Pointers, occupancy, head register and sticky overflow flag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_valid    <= 1'b0;
      r_head     <= 10'd0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= w_rd_ptr_nx;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      r_count <= w_count_nx;
      r_valid <= (w_count_nx != '0);
      r_head  <= w_head_nx;
    end
  end

  assign valid    = r_valid;
  assign data     = r_head[7:0];
  assign extended = r_head[9];
  assign released = r_head[8];
  assign count    = r_count;
  assign err      = r_err;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_ps2_kbd_fifo.sv
// Directed bench for ps2_kbd_fifo: table of frames/pops with hand-computed
// results, plus sequences for timeout, overflow, reset mid-frame and
// simultaneous push/pop while full.
module tb_ps2_kbd_fifo;

  localparam int CLK_HZ      = 1000000;
  localparam int TIMEOUT_MS  = 1;
  localparam int TIMEOUT_CYC = 1000;
  localparam int HALF        = 40;   // PS/2 clock half period in system clocks

  logic       clock;
  logic       reset_n;
  logic       ps_clock;
  logic       ps_data;
  logic       rd;
  logic       valid;
  logic [7:0] data;
  logic       extended;
  logic       released;
  logic [3:0] count;
  logic       err;
  logic       overflow;

  int n_cmp;
  int n_bad;
  int err_cnt;

  ps2_kbd_fifo #(
    .CLK_HZ(CLK_HZ), .TIMEOUT_MS(TIMEOUT_MS), .FIFO_DEPTH(8), .SYNC_STAGES(2)
  ) dut (
    .clock(clock), .reset_n(reset_n), .ps_clock(ps_clock), .ps_data(ps_data),
    .rd(rd), .valid(valid), .data(data), .extended(extended),
    .released(released), .count(count), .err(err), .overflow(overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Count every cycle err is seen high.
  always @(negedge clock) begin
    if (err === 1'b1) err_cnt++;
  end

  // Hard time limit.
  initial begin
    #950000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic       is_pop;
    logic [7:0] code;
    logic       bad;
    logic       ev;
    logic [7:0] ed;
    logic       ee;
    logic       er;
    logic [3:0] ec;
    logic [1:0] eerr;
  } vec_t;

  vec_t tbl [20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Send nbits of a frame; optionally pulse rd in the cycle the stop-bit push lands.
  task automatic send_frame(input logic [7:0] code, input logic bad, input int nbits,
                            input logic rd_at_end);
    logic [10:0] b;
    b = {1'b1, (~^code) ^ bad, code, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps_data = b[i];
      repeat (HALF / 2) @(negedge clock);
      ps_clock = 1'b0;
      if (rd_at_end && (i == 10)) begin
        repeat (2) @(negedge clock);
        rd = 1'b1;
        @(negedge clock);
        rd = 1'b0;
        repeat (HALF - 3) @(negedge clock);
      end else begin
        repeat (HALF) @(negedge clock);
      end
      ps_clock = 1'b1;
      repeat (HALF / 2) @(negedge clock);
    end
    ps_data = 1'b1;
    repeat (5) @(negedge clock);
  endtask

  task automatic do_pop();
    rd = 1'b1;
    @(negedge clock);
    rd = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 32'(valid), 32'd0);
    chk({tag, "_data"}, 32'(data), 32'd0);
    chk({tag, "_ext"}, 32'(extended), 32'd0);
    chk({tag, "_rel"}, 32'(released), 32'd0);
    chk({tag, "_count"}, 32'(count), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_ovf"}, 32'(overflow), 32'd0);
  endtask

  initial begin
    int e0;
    n_cmp = 0; n_bad = 0; err_cnt = 0;
    ps_clock = 1'b1; ps_data = 1'b1; rd = 1'b0; reset_n = 1'b0;

    //            pop   code   bad   ev    ed     ee    er    ec     errs
    tbl[0]  = '{1'b0, 8'h1C, 1'b0, 1'b1, 8'h1C, 1'b0, 1'b0, 4'd1, 2'd0};
    tbl[1]  = '{1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 2'd0};
    tbl[2]  = '{1'b0, 8'hE0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 2'd0};
    tbl[3]  = '{1'b0, 8'hF0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 2'd0};
    tbl[4]  = '{1'b0, 8'h75, 1'b0, 1'b1, 8'h75, 1'b1, 1'b1, 4'd1, 2'd0};
    tbl[5]  = '{1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 2'd0};
    tbl[6]  = '{1'b0, 8'hF0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 2'd0};
    tbl[7]  = '{1'b0, 8'h1C, 1'b0, 1'b1, 8'h1C, 1'b0, 1'b1, 4'd1, 2'd0};
    tbl[8]  = '{1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 2'd0};
    tbl[9]  = '{1'b0, 8'h1C, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 2'd1};
    tbl[10] = '{1'b0, 8'h29, 1'b0, 1'b1, 8'h29, 1'b0, 1'b0, 4'd1, 2'd0};
    tbl[11] = '{1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 2'd0};
    tbl[12] = '{1'b0, 8'hF0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 2'd0};
    tbl[13] = '{1'b0, 8'hE0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 2'd0};
    tbl[14] = '{1'b0, 8'h6B, 1'b0, 1'b1, 8'h6B, 1'b1, 1'b1, 4'd1, 2'd0};
    tbl[15] = '{1'b0, 8'hE0, 1'b0, 1'b1, 8'h6B, 1'b1, 1'b1, 4'd1, 2'd0};
    tbl[16] = '{1'b0, 8'h12, 1'b1, 1'b1, 8'h6B, 1'b1, 1'b1, 4'd1, 2'd1};
    tbl[17] = '{1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 2'd0};
    tbl[18] = '{1'b0, 8'h12, 1'b0, 1'b1, 8'h12, 1'b0, 1'b0, 4'd1, 2'd0};
    tbl[19] = '{1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 2'd0};

    repeat (5) @(negedge clock);
    chk_zero("reset");
    reset_n = 1'b1;
    repeat (5) @(negedge clock);

    // Table-driven frames and pops.
    for (int i = 0; i < 20; i++) begin
      e0 = err_cnt;
      if (tbl[i].is_pop) do_pop();
      else send_frame(tbl[i].code, tbl[i].bad, 11, 1'b0);
      chk($sformatf("v%0d_valid", i), 32'(valid), 32'(tbl[i].ev));
      chk($sformatf("v%0d_data", i), 32'(data), 32'(tbl[i].ed));
      chk($sformatf("v%0d_ext", i), 32'(extended), 32'(tbl[i].ee));
      chk($sformatf("v%0d_rel", i), 32'(released), 32'(tbl[i].er));
      chk($sformatf("v%0d_count", i), 32'(count), 32'(tbl[i].ec));
      chk($sformatf("v%0d_errs", i), 32'(err_cnt - e0), 32'(tbl[i].eerr));
    end

    // Timeout: start plus 4 data bits then the clock stalls high.
    e0 = err_cnt;
    send_frame(8'h5A, 1'b0, 5, 1'b0);
    repeat (TIMEOUT_CYC + 100) @(negedge clock);
    chk("tmo_errs", 32'(err_cnt - e0), 32'd1);
    chk("tmo_count", 32'(count), 32'd0);
    e0 = err_cnt;
    send_frame(8'h5A, 1'b0, 11, 1'b0);
    chk("tmo_next_data", 32'(data), 32'h5A);
    chk("tmo_next_count", 32'(count), 32'd1);
    chk("tmo_next_errs", 32'(err_cnt - e0), 32'd0);
    do_pop();

    // Overflow: nine codes into eight slots.
    for (int c = 1; c <= 9; c++) send_frame(8'(c), 1'b0, 11, 1'b0);
    chk("ovf_count", 32'(count), 32'd8);
    chk("ovf_flag", 32'(overflow), 32'd1);
    for (int c = 1; c <= 8; c++) begin
      chk($sformatf("ovf_pop%0d_valid", c), 32'(valid), 32'd1);
      chk($sformatf("ovf_pop%0d_data", c), 32'(data), 32'(c));
      do_pop();
    end
    chk("ovf_empty_valid", 32'(valid), 32'd0);
    chk("ovf_empty_count", 32'(count), 32'd0);
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // Reset mid-frame with a pending prefix.
    send_frame(8'hE0, 1'b0, 11, 1'b0);
    send_frame(8'h44, 1'b0, 6, 1'b0);
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    chk_zero("midrst");
    reset_n = 1'b1;
    repeat (5) @(negedge clock);
    send_frame(8'h33, 1'b0, 11, 1'b0);
    chk("midrst_data", 32'(data), 32'h33);
    chk("midrst_ext", 32'(extended), 32'd0);
    chk("midrst_count", 32'(count), 32'd1);
    do_pop();

    // Full FIFO with push and pop in the same cycle.
    for (int c = 0; c < 8; c++) send_frame(8'h41 + 8'(c), 1'b0, 11, 1'b0);
    chk("full_count", 32'(count), 32'd8);
    chk("full_ovf", 32'(overflow), 32'd0);
    send_frame(8'h49, 1'b0, 11, 1'b1);
    chk("pp_count", 32'(count), 32'd8);
    chk("pp_ovf", 32'(overflow), 32'd0);
    for (int c = 0; c < 8; c++) begin
      chk($sformatf("pp_pop%0d_data", c), 32'(data), 32'(8'h42 + 8'(c)));
      do_pop();
    end
    chk("pp_empty_valid", 32'(valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
